window3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that feeds the 3x3 weighted-average (blur) kernel. It accepts a raster-order pixel stream (one 4-bit pixel per accepted cycle), stores the two previous image rows in internal line buffers, and emits a registered 9-pixel window p1..p9 for every pixel that has a full 3x3 neighbourhood. It sits between the pixel source and the averaging kernel, which consumes p1..p9 directly.

---
 rtl/window3x3_gen.sv | 136 +++++++++++++
 tb/tb_window3x3_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// window3x3_gen: streaming 3x3 neighbourhood generator for a raster pixel
// stream. Two line buffers hold the previous rows; a 3x3 register array
// shifts left on every accepted pixel and is flagged valid once the
// accepted pixel has a complete neighbourhood (col >= 2, row >= 2).
module window3x3_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [PIX_W-1:0]           in_pix,
  output logic                       win_valid,
  output logic [PIX_W-1:0]           p1,
  output logic [PIX_W-1:0]           p2,
  output logic [PIX_W-1:0]           p3,
  output logic [PIX_W-1:0]           p4,
  output logic [PIX_W-1:0]           p5,
  output logic [PIX_W-1:0]           p6,
  output logic [PIX_W-1:0]           p7,
  output logic [PIX_W-1:0]           p8,
  output logic [PIX_W-1:0]           p9,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  // window registers, index 0..8 maps to p1..p9
  logic [8:0][PIX_W-1:0] win_q, win_d;

  // line buffers: lb0 holds row-2, lb1 holds row-1, indexed by column
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // start-of-frame overrides the counters so the accepted pixel is (0,0)
  always_comb begin
    pos_x  = in_sof ? '0 : col_q;
    pos_y  = in_sof ? '0 : row_q;
    lb0_rd = lb0_q[pos_x];
    lb1_rd = lb1_q[pos_x];
  end

  // next-state: counters, window shift, output flags
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      if (pos_x == X_LAST) begin
        col_d = '0;
        row_d = (pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
      end else begin
        col_d = pos_x + 1'b1;
        row_d = pos_y;
      end
      win_d[0]     = win_q[1];
      win_d[1]     = win_q[2];
      win_d[2]     = lb0_rd;
      win_d[3]     = win_q[4];
      win_d[4]     = win_q[5];
      win_d[5]     = lb1_rd;
      win_d[6]     = win_q[7];
      win_d[7]     = win_q[8];
      win_d[8]     = in_pix;
      out_x_d      = pos_x - XW'(1);
      out_y_d      = pos_y - YW'(1);
      win_valid_d  = (pos_x >= XW'(2)) && (pos_y >= YW'(2));
      frame_done_d = (pos_x == X_LAST) && (pos_y == Y_LAST);
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // line buffers roll one row down on every accept; contents are never reset
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0_q[pos_x] <= lb1_rd;
      lb1_q[pos_x] <= in_pix;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign p1 = win_q[0];
  assign p2 = win_q[1];
  assign p3 = win_q[2];
  assign p4 = win_q[3];
  assign p5 = win_q[4];
  assign p6 = win_q[5];
  assign p7 = win_q[6];
  assign p8 = win_q[7];
  assign p9 = win_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Testbench for window3x3_gen: a 4x4 instance checked against a table and
// an image-array model through an expected-window queue, plus a default
// 64x64 instance fed a diagonal ramp.
module tb_window3x3_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_sof;
  logic [3:0] in_pix;
  logic       win_valid, frame_done;
  logic [3:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [1:0] out_x, out_y;

  logic       r_valid, r_sof;
  logic [3:0] r_pix;
  logic       r_wv, r_fd;
  logic [3:0] r_p1, r_p2, r_p3, r_p4, r_p5, r_p6, r_p7, r_p8, r_p9;
  logic [5:0] r_x, r_y;

  window3x3_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .win_valid(win_valid), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .p6(p6), .p7(p7), .p8(p8), .p9(p9), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done)
  );

  window3x3_gen #(.IMG_W(64), .IMG_H(64), .PIX_W(4)) dut_ramp (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_sof(r_sof), .in_pix(r_pix),
    .win_valid(r_wv), .p1(r_p1), .p2(r_p2), .p3(r_p3), .p4(r_p4), .p5(r_p5),
    .p6(r_p6), .p7(r_p7), .p8(r_p8), .p9(r_p9), .out_x(r_x), .out_y(r_y),
    .frame_done(r_fd)
  );

  typedef struct packed {
    logic [8:0][3:0] p;
    int              x;
    int              y;
    logic            fd;
    int              cyc;
  } exp_t;

  typedef struct packed {
    logic [3:0] pix;
    logic       sof;
    logic       wv;
    exp_t       e;
  } vec_t;

  vec_t       tbl [16];
  exp_t       q [$];
  exp_t       last;
  exp_t       mon_e;
  logic [35:0] act;
  logic [3:0] img [4][4];
  int mx = 0, my = 0;
  int errors = 0, checks = 0, cyc = 0;
  int wcnt = 0, fdcnt = 0, r_wcnt = 0, r_fdcnt = 0;
  bit held_ok = 0;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic chk_p(input string name, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got p9..p1=%h expected %h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkexp(input int a, b, c, d, e, f, g, h, i, x, y, input logic fd);
    exp_t r;
    r.p   = {4'(i), 4'(h), 4'(g), 4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
    r.x   = x;
    r.y   = y;
    r.fd  = fd;
    r.cyc = 0;
    return r;
  endfunction

  // one pixel on the 4x4 instance; expectation comes from the table or the image model
  task automatic drive(input logic [3:0] pix, input logic sof, input logic use_tbl,
                       input exp_t te, input logic twv);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pix   = pix;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my][mx] = pix;
    if (use_tbl) begin
      if (twv) begin
        e     = te;
        e.cyc = cyc + 1;
        q.push_back(e);
      end
    end else if (mx >= 2 && my >= 2) begin
      for (int k = 0; k < 9; k++) e.p[k] = img[my - 2 + k / 3][mx - 2 + k % 3];
      e.x   = mx - 1;
      e.y   = my - 1;
      e.fd  = (mx == 3 && my == 3);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (mx == 3) begin
      mx = 0;
      my = (my == 3) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_pix   = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic send_frame(input bit inv, input bit first_sof, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      drive(inv ? 4'(15 - i) : 4'(i), (i == 0) ? first_sof : 1'b0, 1'b0, '0, 1'b0);
      if (gaps) idle(1);
    end
  endtask

  task automatic end_scn(input string name, input int w0, input int f0, input int ew, input int ef);
    idle(3);
    chk({name, "_windows"}, wcnt - w0, ew);
    chk({name, "_frame_done"}, fdcnt - f0, ef);
    chk({name, "_queue_left"}, q.size(), 0);
  endtask

  // 4x4 monitor: pop expected windows, check held outputs and idle flags
  always @(posedge clk) begin
    #2;
    cyc++;
    act = {p9, p8, p7, p6, p5, p4, p3, p2, p1};
    if (rst) begin
      chk("reset_state", int'({win_valid, frame_done, act, out_x, out_y} == '0), 1);
      held_ok = 0;
    end else if (win_valid) begin
      wcnt++;
      if (frame_done) fdcnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got win_valid=1 at (%0d,%0d) expected none", out_x, out_y);
      end else begin
        mon_e = q.pop_front();
        chk_p("window", act, mon_e.p);
        chk("out_x", int'(out_x), mon_e.x);
        chk("out_y", int'(out_y), mon_e.y);
        chk("frame_done_win", int'(frame_done), int'(mon_e.fd));
        chk("latency_cycle", cyc, mon_e.cyc);
        last    = mon_e;
        held_ok = 1;
      end
    end else begin
      if (frame_done) fdcnt++;
      chk("frame_done_idle", int'(frame_done), 0);
      if (in_valid) begin
        held_ok = 0;
      end else if (held_ok) begin
        chk_p("hold_p", act, last.p);
        chk("hold_x", int'(out_x), last.x);
        chk("hold_y", int'(out_y), last.y);
      end
    end
  end

  // ramp monitor: centre and top-left follow (x+y) mod 16
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (r_fd) r_fdcnt++;
      if (r_wv) begin
        r_wcnt++;
        chk("ramp_p5", int'(r_p5), (int'(r_x) + int'(r_y)) % 16);
        chk("ramp_p1", int'(r_p1), (int'(r_x) + int'(r_y) + 14) % 16);
      end
    end
  end

  initial begin
    int w0, f0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0;
    r_valid = 1'b0; r_sof = 1'b0; r_pix = '0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = 4'(i);
      tbl[i].sof = (i == 0);
      tbl[i].wv  = 1'b0;
      tbl[i].e   = '0;
    end
    tbl[10].wv = 1'b1; tbl[10].e = mkexp(0, 1, 2, 4, 5, 6, 8, 9, 10, 1, 1, 1'b0);
    tbl[11].wv = 1'b1; tbl[11].e = mkexp(1, 2, 3, 5, 6, 7, 9, 10, 11, 2, 1, 1'b0);
    tbl[14].wv = 1'b1; tbl[14].e = mkexp(4, 5, 6, 8, 9, 10, 12, 13, 14, 1, 2, 1'b0);
    tbl[15].wv = 1'b1; tbl[15].e = mkexp(5, 6, 7, 9, 10, 11, 13, 14, 15, 2, 2, 1'b1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // continuous frame from the table
    w0 = wcnt; f0 = fdcnt;
    for (int i = 0; i < 16; i++) drive(tbl[i].pix, tbl[i].sof, 1'b1, tbl[i].e, tbl[i].wv);
    end_scn("continuous", w0, f0, 4, 1);

    // same frame with a gap after every pixel
    w0 = wcnt; f0 = fdcnt;
    send_frame(1'b0, 1'b1, 1'b1);
    end_scn("gapped", w0, f0, 4, 1);

    // back-to-back frames, second inverted
    w0 = wcnt; f0 = fdcnt;
    send_frame(1'b0, 1'b1, 1'b0);
    send_frame(1'b1, 1'b1, 1'b0);
    end_scn("back_to_back", w0, f0, 8, 2);

    // reset after pixel 9, then a frame without sof must still start at (0,0)
    for (int i = 0; i < 10; i++) drive(4'(i), i == 0, 1'b0, '0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    mx = 0; my = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w0 = wcnt; f0 = fdcnt;
    send_frame(1'b0, 1'b0, 1'b0);
    end_scn("after_reset", w0, f0, 4, 1);

    // frame aborted at pixel 6 by a new sof
    w0 = wcnt; f0 = fdcnt;
    for (int i = 0; i < 6; i++) drive(4'(i + 3), i == 0, 1'b0, '0, 1'b0);
    send_frame(1'b0, 1'b1, 1'b0);
    end_scn("sof_abort", w0, f0, 4, 1);

    // default-size ramp frame
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        @(negedge clk);
        r_valid = 1'b1;
        r_sof   = (x == 0 && y == 0);
        r_pix   = 4'((x + y) % 16);
      end
    end
    @(negedge clk);
    r_valid = 1'b0;
    r_sof   = 1'b0;
    repeat (3) @(negedge clk);
    chk("ramp_windows", r_wcnt, 3844);
    chk("ramp_frame_done", r_fdcnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
